riscv_fetch_unit: RTL
=====================

# riscv_fetch_unit

Instruction fetch stage directly upstream of `riscv_controller`. It holds the program counter and fetches one 32-bit instruction per retirement over a request/grant/response handshake to instruction memory. It presents the instruction and its decode fields (`op`, `funct3`, `funct7`) to the controller. It consumes `PCSrc` and `PCTarget` to select the next PC when the core retires the instruction.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request; held until granted.
- `imem_addr` output 32: fetch address; always equals `PC` while `imem_req`=1.
- `imem_gnt` input 1: memory accepted the request this cycle.
- `imem_rvalid` input 1: `imem_rdata` valid this cycle.
- `imem_rdata` input 32: returned instruction word.
- `instr` output 32: current instruction register (IR).
- `instr_valid` output 1: IR holds a fetched, unretired instruction.
- `instr_ready` input 1: core retires the presented instruction this cycle.
- `op` output 7: `instr[6:0]`.
- `funct3` output 3: `instr[14:12]`.
- `funct7` output 1: `instr[30]`.
- `PCSrc` input 1: from controller; 1 selects `PCTarget`.
- `PCTarget` input 32: branch/jump target from the datapath adder.
- `PC` output 32: address of the instruction in IR.
- `PCPlus4` output 32: `PC + 4`, mod 2^32; feeds the JAL/JALR writeback.
- `fetch_fault` output 1: sticky misaligned-target flag. Present only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, and FAULT (FAULT exists only with the macro).
- IDLE: entered on reset. Moves to REQ on the first clock edge after `rst_n` deasserts.
- REQ: `imem_req`=1, `imem_addr`=`PC`.
  - `imem_gnt`=1 -> WAIT.
  - `imem_rvalid` is ignored in REQ.
- WAIT: `imem_req`=0. `imem_rvalid`=1 -> IR <= `imem_rdata`, then HOLD.
- HOLD: `instr_valid`=1. IR, `PC` and the decode fields are stable.
  - `instr_ready`=1 -> `PC` <= `PCSrc` ? `PCTarget` : `PCPlus4`, then REQ.
  - `PCSrc` and `PCTarget` are sampled only in the HOLD && `instr_ready` cycle; other values are don't-care.
- `instr_ready` is ignored outside HOLD.
- `imem_rvalid` is ignored in IDLE, REQ and HOLD. A response still in flight when reset asserts is therefore discarded.
- `PCPlus4` is combinational from `PC`. Wrap from 32'hFFFF_FFFC gives 0.
- Decode fields are combinational slices of IR.
- Reset values:
  - `PC`=`RESET_PC`; IR=32'h0000_0013 (NOP), so `op`=7'h13, `funct3`=0, `funct7`=0.
  - `imem_req`=0, `instr_valid`=0, `fetch_fault`=0.

## Timing
- Best case (grant in the REQ cycle, rvalid one cycle after grant, ready in the first HOLD cycle): 3 cycles per instruction (REQ, WAIT, HOLD).
- Each extra cycle without grant, rvalid or ready adds exactly one cycle.
- IR is written only on the WAIT-to-HOLD edge; `PC` is written only on the HOLD-exit edge. The two never update in the same cycle.
- Reset assertion in any state forces IDLE immediately (asynchronously), with the reset values on all outputs.
- Throughput is one instruction per 3 cycles minimum.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - On HOLD && `instr_ready` && `PCSrc` && `PCTarget[1:0]`!=0: `PC` is not updated, `fetch_fault` <= 1, and the FSM moves to FAULT.
  - FAULT: `imem_req`=0, `instr_valid`=0. FAULT is left only by reset.
- Undefined:
  - No `fetch_fault` port and no FAULT state.
  - The selected target is loaded with bits [1:0] forced to 2'b00.

## Structure
- Package `riscv_fetch_pkg` holds:
  - the FSM state enum;
  - `NOP_INSTR` = 32'h0000_0013;
  - the `RESET_PC` default.
- One sub-module, `riscv_pc_next`: combinational `PCPlus4` adder, `PCSrc` mux, and alignment handling (forcing or fault detect per the macro).
- Top level holds the FSM, the PC register and IR.

## Test plan
- Reset with `RESET_PC`=0x100, gnt always 1, rvalid one cycle after grant, ready=1, `PCSrc`=0:
  - `imem_addr` sequence 0x100, 0x104, 0x108;
  - `instr_valid` pulses every 3 cycles;
  - `op`/`funct3`/`funct7` match each returned word.
- In HOLD, `PCSrc`=1 with `PCTarget`=0x200 -> next `imem_addr`=0x200 and `PCPlus4`=0x204 on the following HOLD.
- Withhold gnt for 4 cycles and rvalid for 3 cycles:
  - `imem_req` and `imem_addr` stay stable;
  - IR is unchanged until rvalid;
  - no `PC` change.
- Assert `rst_n`=0 during WAIT, release, then drive a stale rvalid in REQ:
  - stale data is not captured;
  - IR reads 0x00000013;
  - refetch starts from `RESET_PC`.
- `PCSrc`=1 with `PCTarget`=0x202:
  - with the macro: `fetch_fault`=1, `imem_req` stays 0 until reset;
  - without the macro: next `imem_addr`=0x200.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the riscv_fetch_unit slice.
// Optional misaligned-target trap enabled by FETCH_MISALIGN_TRAP_EN.
package riscv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        S_FAULT
`endif
    } state_t;

endpackage

// File: rtl/riscv_fetch_unit_pc_next.sv
// Next-PC logic: PC+4 adder, branch/jump mux and target alignment.
// FETCH_MISALIGN_TRAP_EN flags misaligned targets instead of forcing alignment.
module riscv_pc_next (
    input  logic [31:0] pc,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic [31:0] pc_plus4,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic [31:0] pc_next
);

    logic [31:0] sel;

    assign pc_plus4 = pc + 32'd4;
    assign sel      = pc_src ? pc_target : pc_plus4;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = pc_src && (pc_target[1:0] != 2'b00);
    assign pc_next    = sel;
`else
    // Low bits of a jump target are dropped rather than trapped.
    assign pc_next    = sel & ~32'h3;
`endif

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: PC, IR and req/gnt/rvalid handshake FSM.
// Optional sticky fetch_fault trap enabled by FETCH_MISALIGN_TRAP_EN.
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic [31:0] PC,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        fetch_fault,
`endif
    output logic [31:0] PCPlus4
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] pc_next;
    logic        retire;
    logic        bad_target;

    riscv_pc_next u_pc_next (
        .pc        (pc_q),
        .pc_src    (PCSrc),
        .pc_target (PCTarget),
        .pc_plus4  (PCPlus4),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned(bad_target),
`endif
        .pc_next   (pc_next)
    );

`ifndef FETCH_MISALIGN_TRAP_EN
    assign bad_target = 1'b0;
`endif

    assign retire = (state_q == S_HOLD) && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (imem_gnt)    state_d = S_WAIT;
            S_WAIT: if (imem_rvalid) state_d = S_HOLD;
            S_HOLD: if (instr_ready) state_d = bad_target ? state_q : S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
            S_FAULT: state_d = S_FAULT;
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (retire && bad_target) state_d = S_FAULT;
`endif
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_fault = 1'b0;
`endif
        unique case (state_q)
            S_REQ:  imem_req    = 1'b1;
            S_HOLD: instr_valid = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            // FAULT is only left by reset, so the flag is sticky.
            S_FAULT: fetch_fault = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (retire && !bad_target) begin
            pc_q <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= NOP_INSTR;
        end else if ((state_q == S_WAIT) && imem_rvalid) begin
            ir_q <= imem_rdata;
        end
    end

    assign PC        = pc_q;
    assign imem_addr = pc_q;
    assign instr     = ir_q;
    assign op        = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7    = ir_q[30];

endmodule
